// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the MEM-stage access controller, the EX/MEM register and the data memory.
// The master modport is the controller; the slave modport is its surroundings (pipeline + memory).
interface dmem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  MemRead_i;
  logic                  MemWrite_i;
  logic [ADDR_WIDTH-1:0] Addr_i;
  logic [DATA_WIDTH-1:0] WriteData_i;
  logic                  MemReq_o;
  logic                  MemWE_o;
  logic [ADDR_WIDTH-1:0] MemAddr_o;
  logic [DATA_WIDTH-1:0] MemWData_o;
  logic                  MemAck_i;
  logic [DATA_WIDTH-1:0] MemRData_i;
  logic [DATA_WIDTH-1:0] ReadData_o;
  logic                  Stall_o;
  logic                  Err_o;
  logic [31:0]           StallCycles_o;

  modport master (
    input  MemRead_i, MemWrite_i, Addr_i, WriteData_i, MemAck_i, MemRData_i,
    output MemReq_o, MemWE_o, MemAddr_o, MemWData_o, ReadData_o, Stall_o, Err_o,
           StallCycles_o
  );

  modport slave (
    output MemRead_i, MemWrite_i, Addr_i, WriteData_i, MemAck_i, MemRData_i,
    input  MemReq_o, MemWE_o, MemAddr_o, MemWData_o, ReadData_o, Stall_o, Err_o,
           StallCycles_o
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one request per load/store, pipeline stall until ack or
// watchdog expiry, then one DONE cycle presenting the load result.
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dmem_access_ctrl_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic                  access;
  logic                  stall;
  logic                  timeout_hit;

  assign access      = bus.MemRead_i | bus.MemWrite_i;
  assign stall       = ((state_q == S_IDLE) && access) || (state_q == S_REQ);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d  = bus.Addr_i;
          wdata_d = bus.WriteData_i;
          we_d    = bus.MemWrite_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Ack takes priority so a response landing on the last watchdog cycle is not lost.
        if (bus.MemAck_i) begin
          if (!we_q) rdata_d = bus.MemRData_i;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.MemReq_o      = req_q;
  assign bus.MemWE_o       = we_q;
  assign bus.MemAddr_o     = addr_q;
  assign bus.MemWData_o    = wdata_q;
  assign bus.ReadData_o    = rdata_q;
  assign bus.Stall_o       = stall;
  assign bus.Err_o         = err_q;
  assign bus.StallCycles_o = stall_cnt_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl (TIMEOUT=4): directed scenarios plus random accesses checked
// against a transaction-level model of stall length, load result, error flag and stall count.
module tb_dmem_access_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   req_rises;
  logic req_prev;

  // Transaction-level model state
  logic [31:0]   model_stall;
  logic [DW-1:0] model_rd;

  dmem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.MemReq_o === 1'b1 && req_prev !== 1'b1) req_rises = req_rises + 1;
    req_prev = bus.MemReq_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access from its IDLE cycle through DONE; ack_at = REQ cycle of the ack pulse, 0 = never.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int ack_at);
    bit            acked;
    int            nreq;
    logic [DW-1:0] exp_rd;
    longint        tmp;
    acked  = (ack_at != 0) && (ack_at <= TO);
    nreq   = acked ? ack_at : TO;
    exp_rd = acked ? (wr ? model_rd : rdata) : '0;
    tmp    = longint'(model_stall) + nreq + 1;
    bus.MemRead_i   = rd;
    bus.MemWrite_i  = wr;
    bus.Addr_i      = addr;
    bus.WriteData_i = wdata;
    bus.MemAck_i    = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.Stall_o, bus.MemReq_o, bus.Err_o} !== 3'b100) begin
      errors++;
      $display("FAIL idle_issue: stall/req/err=%b required 100", {bus.Stall_o, bus.MemReq_o, bus.Err_o});
    end
    for (int j = 1; j <= nreq; j++) begin
      step();
      bus.MemAck_i    = (j == ack_at);
      bus.MemRData_i  = (j == ack_at) ? rdata : DW'($urandom);
      bus.Addr_i      = AW'($urandom);
      bus.WriteData_i = DW'($urandom);
      @(negedge clk);
      checks++;
      if ({bus.MemReq_o, bus.MemWE_o, bus.Stall_o, bus.Err_o, bus.MemAddr_o, bus.MemWData_o}
          !== {1'b1, wr, 1'b1, 1'b0, addr, wdata}) begin
        errors++;
        $display("FAIL req_cycle%0d: req=%b we=%b stall=%b err=%b addr=%h wdata=%h required 1 %b 1 0 %h %h",
                 j, bus.MemReq_o, bus.MemWE_o, bus.Stall_o, bus.Err_o, bus.MemAddr_o,
                 bus.MemWData_o, wr, addr, wdata);
      end
    end
    step();
    bus.MemAck_i   = 1'b0;
    bus.MemRData_i = DW'($urandom);
    model_stall = (tmp > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(tmp);
    model_rd    = exp_rd;
    @(negedge clk);
    checks++;
    if ({bus.MemReq_o, bus.Stall_o, bus.Err_o} !== {2'b00, !acked}) begin
      errors++;
      $display("FAIL done_flags: req/stall/err=%b required 00%b", {bus.MemReq_o, bus.Stall_o, bus.Err_o}, !acked);
    end
    checks++;
    if (bus.ReadData_o !== exp_rd) begin
      errors++;
      $display("FAIL done_rdata: got %h required %h", bus.ReadData_o, exp_rd);
    end
    checks++;
    if (bus.StallCycles_o !== model_stall) begin
      errors++;
      $display("FAIL stall_count: got %0d required %0d", bus.StallCycles_o, model_stall);
    end
    step();
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.Addr_i = AW'($urandom);
      @(negedge clk);
      checks++;
      if ({bus.Stall_o, bus.MemReq_o, bus.Err_o} !== 3'b000 || bus.StallCycles_o !== model_stall) begin
        errors++;
        $display("FAIL idle: stall/req/err=%b count=%0d required 000 count=%0d",
                 {bus.Stall_o, bus.MemReq_o, bus.Err_o}, bus.StallCycles_o, model_stall);
      end
      step();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.MemReq_o, bus.MemWE_o, bus.Stall_o, bus.Err_o} !== 4'b0000 ||
        bus.MemAddr_o !== '0 || bus.MemWData_o !== '0 || bus.ReadData_o !== '0 ||
        bus.StallCycles_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b stall=%b err=%b addr=%h wd=%h rd=%h cnt=%0d required all 0",
               bus.MemReq_o, bus.MemWE_o, bus.Stall_o, bus.Err_o, bus.MemAddr_o, bus.MemWData_o,
               bus.ReadData_o, bus.StallCycles_o);
    end
    step();
    rst_n = 1'b1;
    model_stall = 0;
    model_rd    = '0;
    idle_cycles(3);
  endtask

  task automatic test_load();
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_0000, 1);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = req_rises;
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 2);
    do_access(1'b0, 1'b1, 32'h0000_0104, 32'h5A5A_0002, 32'h0, 1);
    idle_cycles(1);
    checks++;
    if (req_rises - r0 !== 2) begin
      errors++;
      $display("FAIL b2b_req_count: got %0d required 2", req_rises - r0);
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222, 0);
    idle_cycles(1);
    do_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h3333_4444, TO);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_req();
    bus.MemRead_i = 1'b1;
    bus.Addr_i    = 32'h0000_0300;
    step();
    step();
    rst_n = 1'b0;
    bus.MemRead_i = 1'b0;
    step();
    model_stall = 0;
    model_rd    = '0;
    rst_n = 1'b1;
    bus.MemAck_i   = 1'b1;
    bus.MemRData_i = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if ({bus.MemReq_o, bus.Stall_o, bus.Err_o, bus.MemWE_o} !== 4'b0000 || bus.MemAddr_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_req: req/stall/err/we=%b addr=%h required 0000 0",
               {bus.MemReq_o, bus.Stall_o, bus.Err_o, bus.MemWE_o}, bus.MemAddr_o);
    end
    step();
    bus.MemAck_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.StallCycles_o !== 32'd0 || bus.ReadData_o !== '0 || bus.MemReq_o !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: cnt=%0d rd=%h req=%b required 0 0 0",
               bus.StallCycles_o, bus.ReadData_o, bus.MemReq_o);
    end
    step();
  endtask

  task automatic test_both_and_stray_ack();
    do_access(1'b1, 1'b1, 32'h0000_0400, 32'h7777_8888, 32'h9999_AAAA, 2);
    bus.MemAck_i   = 1'b1;
    bus.MemRData_i = 32'hFEED_FACE;
    @(negedge clk);
    checks++;
    if ({bus.Stall_o, bus.MemReq_o} !== 2'b00) begin
      errors++;
      $display("FAIL stray_ack_now: stall/req=%b required 00", {bus.Stall_o, bus.MemReq_o});
    end
    step();
    bus.MemAck_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ReadData_o !== model_rd || bus.Err_o !== 1'b0 || bus.MemReq_o !== 1'b0 ||
        bus.StallCycles_o !== model_stall) begin
      errors++;
      $display("FAIL stray_ack_after: rd=%h err=%b req=%b cnt=%0d required %h 0 0 %0d",
               bus.ReadData_o, bus.Err_o, bus.MemReq_o, bus.StallCycles_o, model_rd, model_stall);
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_access(kind != 1, kind != 0, AW'($urandom), DW'($urandom), DW'($urandom),
                $urandom_range(0, 6));
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    req_rises = 0;
    req_prev = 1'b0;
    model_stall = 0;
    model_rd = '0;
    rst_n = 1'b0;
    bus.MemRead_i   = 1'b0;
    bus.MemWrite_i  = 1'b0;
    bus.Addr_i      = '0;
    bus.WriteData_i = '0;
    bus.MemAck_i    = 1'b0;
    bus.MemRData_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    test_both_and_stray_ack();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage against a multi-cycle, ack-based data memory. It watches the control and data outputs of the EX/MEM pipeline register and issues one request per load or store. It holds the pipeline stalled until the memory acknowledges or a watchdog expires. It then presents load data to the MEM/WB path for exactly one cycle.

Parameters:
ADDR_WIDTH, 32, width of the memory address (taken from the ALU result).
DATA_WIDTH, 32, width of the load/store data.
TIMEOUT, 64, number of cycles in REQ without ack before abort; 0 disables the watchdog.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-low.
MemRead_i  in  1  load pending in EX/MEM.
MemWrite_i  in  1  store pending in EX/MEM.
Addr_i  in  ADDR_WIDTH  EX/MEM ALU result, used as the address.
WriteData_i  in  DATA_WIDTH  EX/MEM rs2 data (store data).
MemReq_o  out  1  request to the memory; held until ack.
MemWE_o  out  1  1 = write, 0 = read; valid while MemReq_o=1.
MemAddr_o  out  ADDR_WIDTH  latched address.
MemWData_o  out  DATA_WIDTH  latched store data.
MemAck_i  in  1  memory completion, 1-cycle pulse.
MemRData_i  in  DATA_WIDTH  read data; valid when MemAck_i=1.
ReadData_o  out  DATA_WIDTH  load result to MEM/WB; valid in DONE.
Stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, and bubble MEM/WB.
Err_o  out  1  1-cycle pulse in DONE when the access timed out.
StallCycles_o  out  32  saturating count of cycles with Stall_o=1.

Behaviour:
- Reset (rst_i=0 at an edge): state=IDLE. MemReq_o, MemWE_o, MemAddr_o, MemWData_o, ReadData_o, Err_o, StallCycles_o all go to 0. Stall_o=0 combinationally while the state is IDLE with no access pending.
- Reset mid-REQ: MemReq_o drops at that edge; an in-flight ack in later cycles is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, access = MemRead_i|MemWrite_i:
  - Stall_o is driven combinationally high in the same cycle.
  - At the edge: latch Addr_i into MemAddr_o and WriteData_i into MemWData_o; set MemWE_o=MemWrite_i (store wins if both are set); MemReq_o<=1; clear the timeout counter; go to REQ.
- REQ: Stall_o=1; MemReq_o, MemWE_o, MemAddr_o and MemWData_o are held stable.
  - MemAck_i=1: ReadData_o<=MemRData_i if it is a read, else unchanged; MemReq_o<=0; go to DONE.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: ReadData_o<=0; Err_o<=1; MemReq_o<=0; go to DONE.
  - Otherwise counter++.
  - If ack and timeout coincide in the same cycle, ack wins and Err_o stays 0.
- DONE: Stall_o=0, so the pipeline advances this cycle; ReadData_o valid.
  - MemRead_i/MemWrite_i are ignored here, because EX/MEM still holds the completed instruction.
  - Next edge: go to IDLE and clear Err_o.
- Back-to-back accesses: the next instruction is seen in IDLE one cycle after DONE; there is no missed access and no double issue.
- MemAck_i outside REQ is ignored.
- Latency: access seen at cycle T, REQ from T+1, ack at T+k (k>=1), DONE at T+k+1. Stall_o is high for T..T+k, i.e. k+1 cycles (minimum 2).
- StallCycles_o increments at each edge where Stall_o=1. It saturates at 0xFFFFFFFF and is cleared only by reset.
- No access pending: the block stays in IDLE with Stall_o=0; MemReq_o is never asserted.

Test Plan:
- Load, ack at T+3: MemRead_i=1, Addr_i=0x0000_0010, MemRData_i=0xDEADBEEF. Expect MemReq_o=1 from T+1..T+3 with MemWE_o=0 and MemAddr_o=0x10; Stall_o=1 for T..T+3; DONE at T+4 with ReadData_o=0xDEADBEEF and Stall_o=0; StallCycles_o=4.
- Store, ack at T+1: MemWrite_i=1, Addr_i=0x20, WriteData_i=0x1234_5678. Expect MemWE_o=1, MemWData_o=0x12345678; Stall_o high for exactly 2 cycles; ReadData_o unchanged.
- Back-to-back load then store: verify exactly 2 MemReq_o assertions, one idle DONE cycle between them, and no request issued in DONE.
- Timeout with TIMEOUT=4, no ack: expect MemReq_o high for 4 cycles, then DONE with Err_o=1 and ReadData_o=0; IDLE next cycle. Repeat with ack on the 4th REQ cycle: expect Err_o=0.
- Reset mid-REQ: rst_i=0 during the 2nd REQ cycle. Expect all outputs 0 after that edge; an ack pulse 1 cycle later has no effect and StallCycles_o stays 0.
- MemRead_i=MemWrite_i=1: expect a write request (MemWE_o=1). Stray MemAck_i in IDLE: no state change.
